// File: rtl/pc_next_unit_pkg.sv
// pc_next_unit shared definitions: branch funct3 codes,
// FSM state encoding and default PC vectors.
package pc_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// Fetch-side bundle between the PC unit and instruction memory:
// request/ready handshake plus the fetch address and link value.
interface pc_next_unit_if #(
    parameter int XLEN = 32
) ();

    logic            imem_req;
    logic            imem_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    modport master (
        output imem_req,
        output pc,
        output pc_plus4,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  pc,
        input  pc_plus4,
        output imem_ready
    );

endinterface

// File: rtl/pc_next_unit_branch_decide.sv
// Branch condition decode from funct3 and comparator flags,
// plus the unsigned-compare select for the comparator.
module branch_decide
    import pc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       BrEq,
    input  logic       BrLt,
    output logic       cond,
    output logic       bru
);

    // Unsigned select depends on funct3 alone, never on the flags.
    assign bru = funct3[1];

    // Evaluate the branch condition selected by funct3.
    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            F3_BEQ:  cond = BrEq;
            F3_BNE:  cond = !BrEq;
            F3_BLT:  cond = BrLt;
            F3_BGE:  cond = !BrLt;
            F3_BLTU: cond = BrLt;
            F3_BGEU: cond = !BrLt;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter owner: resolves branch/JAL/JALR redirects,
// gates advance on imem ready, traps misaligned targets.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [XLEN-1:0] TRAP_VEC  = DEF_TRAP_VEC,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_next_unit_if.master   fetch,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic             BrEq,
    input  logic             BrLt,
    output logic             BrUn,
    output logic             taken,
    output logic             trap,
    input  logic             trap_ack,
    output logic [XLEN-1:0]  mtval,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] tk_cnt
);

    pc_state_t       state;
    logic [XLEN-1:0] pc_q;
    logic            req_q;
    logic            cond;
    logic            bru;
    logic            br_taken;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            commit;

    branch_decide u_decide (
        .funct3 (funct3),
        .BrEq   (BrEq),
        .BrLt   (BrLt),
        .cond   (cond),
        .bru    (bru)
    );

    assign BrUn     = branch & bru;
    assign br_taken = branch & cond;

    assign fetch.pc       = pc_q;
    assign fetch.pc_plus4 = pc_q + XLEN'(4);
    assign fetch.imem_req = req_q;

    // Redirect target selection: jalr outranks jal and branch.
    always_comb begin
        jalr_sum = rs1_data + imm;
        pc_rel   = pc_q + imm;
        target   = pc_rel;
        if (jalr) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    assign taken      = jalr | jal | br_taken;
    assign next_pc    = taken ? target : fetch.pc_plus4;
    assign misaligned = taken & (target[1:0] != 2'b00);
    assign commit     = (state == RUN) & fetch.imem_ready;

    // Control FSM with PC register, trap flag and registered fetch request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc_q  <= RESET_VEC;
            req_q <= 1'b0;
            trap  <= 1'b0;
            mtval <= '0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= RUN;
                    req_q <= 1'b1;
                end
                RUN: begin
                    if (fetch.imem_ready) begin
                        if (misaligned) begin
                            state <= TRAP;
                            pc_q  <= TRAP_VEC;
                            mtval <= target;
                            trap  <= 1'b1;
                            req_q <= 1'b0;
                        end else begin
                            pc_q <= next_pc;
                        end
                    end
                end
                TRAP: begin
                    if (trap_ack) begin
                        state <= RUN;
                        trap  <= 1'b0;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    req_q <= 1'b0;
                    trap  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating branch and taken-branch counters, bumped on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt <= '0;
            tk_cnt <= '0;
        end else if (commit && branch) begin
            if (br_cnt != '1) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (br_taken && (tk_cnt != '1)) begin
                tk_cnt <= tk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Consumes the branch comparator's BrEq/BrLt and drives its BrUn select.
- Owns the program counter register and resolves branch, JAL and JALR redirects.
- Gates PC advance on an instruction-memory ready handshake and traps misaligned redirect targets.
- Keeps saturating branch and taken-branch performance counters.

Parameters:
XLEN, 32, datapath/PC width
RESET_VEC, 32'h0000_0000, PC value loaded by reset
TRAP_VEC, 32'h0000_0100, PC value loaded on misaligned-target trap
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_ready  in  1  instruction at pc is valid; current instruction commits this cycle
imem_req  out  1  fetch request for pc
branch  in  1  current instruction is a conditional branch
jal  in  1  current instruction is JAL
jalr  in  1  current instruction is JALR
funct3  in  3  branch condition field
imm  in  XLEN  sign-extended immediate
rs1_data  in  XLEN  rs1 value (JALR base)
BrEq  in  1  from comparator: dataA == dataB
BrLt  in  1  from comparator: dataA < dataB (signedness per BrUn)
BrUn  out  1  to comparator: 1 = unsigned compare
pc  out  XLEN  current PC
pc_plus4  out  XLEN  pc + 4 (link value)
taken  out  1  redirect taken this cycle (combinational)
trap  out  1  misaligned-target trap pending
trap_ack  in  1  trap acknowledged, resume at TRAP_VEC
mtval  out  XLEN  faulting target address
br_cnt  out  CNT_W  committed conditional branches
tk_cnt  out  CNT_W  committed taken conditional branches

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VEC, state=BOOT, trap=0, mtval=0, br_cnt=0, tk_cnt=0.
  - imem_req=0. Combinational outputs follow their equations.
  - Reset mid-trap or mid-stall discards all pending state.
- FSM states: BOOT, RUN, TRAP.
  - BOOT: imem_req=0. Unconditionally goes to RUN on the next edge; pc holds RESET_VEC.
  - RUN: imem_req=1. A commit is RUN & imem_ready at a rising edge.
    - On commit, pc <= next_pc, or state goes to TRAP if the redirect target is misaligned.
    - With imem_ready=0, pc, counters and state all hold; control inputs are ignored.
  - TRAP: imem_req=0, trap=1, pc=TRAP_VEC, mtval=faulting target. When trap_ack=1, state goes to RUN with pc staying at TRAP_VEC and trap cleared. trap_ack is ignored outside TRAP.
- BrUn = branch & funct3[1]. It is a combinational function of branch and funct3 only; it never depends on BrEq or BrLt.
- Condition by funct3:
  - 000 BEQ: BrEq
  - 001 BNE: !BrEq
  - 100 BLT: BrLt
  - 101 BGE: !BrLt
  - 110 BLTU: BrLt
  - 111 BGEU: !BrLt
  - 010 and 011: not taken
- Redirect priority when flags overlap: jalr > jal > branch.
  - jalr target = (rs1_data + imm) & ~1.
  - jal and branch target = pc + imm.
  - taken = jalr | jal | (branch & cond). It is also valid outside RUN but has no effect there.
- next_pc = taken ? target : pc_plus4. All adds are modulo 2^XLEN, so 32'hFFFF_FFFC + 4 = 0.
- Misaligned trap:
  - Condition: taken & target[1:0] != 0 at commit.
  - Action: state <= TRAP, pc <= TRAP_VEC, mtval <= target.
  - A non-taken branch never traps, whatever its offset.
- Counters, updated on commit with branch=1 (even if jal or jalr is also asserted):
  - br_cnt increments; tk_cnt also increments if branch & cond.
  - Both saturate at all-ones and never wrap. A trapping branch still counts.
- Latency: taken, BrUn and next_pc are combinational; pc updates one edge after commit.

Decomposition:
- Package pc_pkg holds:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - FSM state encoding (BOOT, RUN, TRAP)
  - default vector constants
- One combinational sub-module, branch_decide, takes funct3, BrEq and BrLt and returns cond and BrUn.
- The top level holds the FSM, PC register, target adders and counters.

Test Plan:
- Reset released, imem_ready=1, no control flags: pc=0 during BOOT, imem_req=0; then pc=0, 4, 8 on consecutive edges.
- pc=0x40, branch=1, funct3=110, BrLt=1, imm=0x20: BrUn=1, taken=1, pc becomes 0x60, br_cnt=1, tk_cnt=1. Repeat with funct3=101, BrLt=1: not taken, pc=0x64, br_cnt=2, tk_cnt=1.
- imem_ready=0 for 3 cycles while jal=1, imm=0x100: pc, br_cnt and tk_cnt unchanged. Raise imem_ready: pc = old pc + 0x100.
- jalr=1, rs1_data=0x1001, imm=0x2: target 0x1002 is misaligned. Expect state TRAP, trap=1, pc=0x100, mtval=0x1002. Hold trap_ack=0 for 2 cycles: no change. trap_ack=1: trap=0, pc=0x100, fetch resumes.
- CNT_W=4, 20 committed taken BEQ (BrEq=1): br_cnt=tk_cnt=4'hF, no wrap.
- Drive rst_n low asynchronously mid-TRAP: trap=0, mtval=0, pc=RESET_VEC, counters=0 immediately, before any clock edge.
